// File: rtl/clock_time_keeper.sv
// Time-of-day keeper: 24-hour hh:mm:ss driven by a half-second tick, with
// RUN / SET_HOUR / SET_MIN modes, press and hold-to-repeat field setting,
// blink phase for the field being set, and a tick-generator resync pulse
// on return to RUN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | time advances one second per two half_tick pulses
// SET_HOUR | btn_inc (edge or auto-repeat) steps hours, seconds frozen
// SET_MIN  | btn_inc (edge or auto-repeat) steps minutes, seconds frozen
module clock_time_keeper #(
  parameter int HOLD_HALF_TICKS = 4
) (
  input  logic       ck,
  input  logic       reset,
  input  logic       half_tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic       tick_clear,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [1:0] mode,
  output logic       blink
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10
  } state_t;

  localparam logic [2:0] HOLD_MAX = 3'(HOLD_HALF_TICKS);

  state_t     state;
  state_t     state_nxt;
  logic       mode_prev;
  logic       inc_prev;
  logic       mode_edge;
  logic       inc_edge;
  logic       half_phase;
  logic [2:0] hold_cnt;
  logic       auto_inc;
  logic       bump;

  assign mode_edge = btn_mode & ~mode_prev;
  assign inc_edge  = btn_inc & ~inc_prev;
  assign mode      = state;

  // Auto-repeat fires only once the hold counter has saturated.
  assign auto_inc = btn_inc & half_tick & (hold_cnt == HOLD_MAX);
  assign bump     = inc_edge | auto_inc;

  // State register.
  always_ff @(posedge ck) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  // Mode sequencing: each btn_mode edge advances one step around the ring.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:      if (mode_edge) state_nxt = SET_HOUR;
      SET_HOUR: if (mode_edge) state_nxt = SET_MIN;
      SET_MIN:  if (mode_edge) state_nxt = RUN;
      default:  state_nxt = RUN;
    endcase
  end

  // Timekeeping, field setting, blink phase and button history.
  always_ff @(posedge ck) begin
    if (reset) begin
      hours      <= '0;
      minutes    <= '0;
      seconds    <= '0;
      blink      <= 1'b0;
      tick_clear <= 1'b0;
      half_phase <= 1'b0;
      hold_cnt   <= '0;
      mode_prev  <= 1'b0;
      inc_prev   <= 1'b0;
    end else begin
      mode_prev  <= btn_mode;
      inc_prev   <= btn_inc;
      tick_clear <= 1'b0;
      if (state_nxt != state) begin
        // A mode change swallows any coincident tick or increment.
        hold_cnt <= '0;
        blink    <= 1'b0;
        if (state == SET_MIN) begin
          seconds    <= '0;
          half_phase <= 1'b0;
          tick_clear <= 1'b1;
        end
      end else if (state == RUN) begin
        if (half_tick) begin
          half_phase <= ~half_phase;
          if (half_phase) begin
            if (seconds == 6'd59) begin
              seconds <= '0;
              if (minutes == 6'd59) begin
                minutes <= '0;
                hours   <= (hours == 5'd23) ? 5'd0 : hours + 5'd1;
              end else begin
                minutes <= minutes + 6'd1;
              end
            end else begin
              seconds <= seconds + 6'd1;
            end
          end
        end
      end else begin
        if (half_tick) blink <= ~blink;
        if (!btn_inc)
          hold_cnt <= '0;
        else if (half_tick && hold_cnt != HOLD_MAX)
          hold_cnt <= hold_cnt + 3'd1;
        if (bump) begin
          if (state == SET_HOUR)
            hours <= (hours == 5'd23) ? 5'd0 : hours + 5'd1;
          else
            minutes <= (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_time_keeper.sv
// Bench for clock_time_keeper: each scenario records expected output words
// alongside sampled DUT outputs and compares them at the end of the scenario.
module tb_clock_time_keeper;

  logic       ck = 1'b0;
  logic       reset = 1'b1;
  logic       half_tick = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       tick_clear;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [1:0] mode;
  logic       blink;

  int n_total = 0;
  int n_pass  = 0;

  logic [20:0] exp_q[$];
  logic [20:0] obs_q[$];
  string       name_q[$];

  clock_time_keeper #(.HOLD_HALF_TICKS(4)) dut (
    .ck(ck), .reset(reset), .half_tick(half_tick), .btn_mode(btn_mode),
    .btn_inc(btn_inc), .tick_clear(tick_clear), .hours(hours),
    .minutes(minutes), .seconds(seconds), .mode(mode), .blink(blink)
  );

  always #5 ck = ~ck;

  function automatic logic [20:0] pk(int h, int m, int s, int md, int bl, int tc);
    return {5'(h), 6'(m), 6'(s), 2'(md), 1'(bl), 1'(tc)};
  endfunction

  // Record an expected word together with the current DUT outputs.
  task automatic rec(string nm, logic [20:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
    obs_q.push_back({hours, minutes, seconds, mode, blink, tick_clear});
  endtask

  task automatic cyc();
    @(posedge ck);
    #1;
  endtask

  task automatic tick();
    half_tick = 1'b1; cyc();
    half_tick = 1'b0; cyc();
  endtask

  task automatic press_mode();
    btn_mode = 1'b1; cyc();
    btn_mode = 1'b0; cyc();
  endtask

  task automatic press_inc(int n);
    for (int i = 0; i < n; i++) begin
      btn_inc = 1'b1; cyc();
      btn_inc = 1'b0; cyc();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; cyc();
    reset = 1'b0; cyc();
  endtask

  task automatic preset(int h, int m);
    press_mode();
    press_inc(h);
    press_mode();
    press_inc(m);
    press_mode();
  endtask

  task automatic test_reset();
    logic [20:0] e, o; string nm;
    reset = 1'b1; cyc();
    rec("reset_initial", pk(0, 0, 0, 0, 0, 0));
    reset = 1'b0; cyc();
    press_mode(); press_inc(2); tick();
    rec("pre_reset_set_hour", pk(2, 0, 0, 1, 1, 0));
    reset = 1'b1; btn_inc = 1'b1; cyc();
    rec("reset_mid_set", pk(0, 0, 0, 0, 0, 0));
    reset = 1'b0; btn_inc = 1'b0; cyc();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      n_total++;
      if (o !== e) $display("FAIL %s got=%h expected=%h", nm, o, e);
      else n_pass++;
    end
  endtask

  task automatic test_rollover();
    logic [20:0] e, o; string nm;
    do_reset();
    preset(23, 59);
    repeat (116) tick();
    rec("run_to_23_59_58", pk(23, 59, 58, 0, 0, 0));
    tick(); tick();
    rec("run_to_23_59_59", pk(23, 59, 59, 0, 0, 0));
    tick(); tick();
    rec("midnight_wrap", pk(0, 0, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      n_total++;
      if (o !== e) $display("FAIL %s got=%h expected=%h", nm, o, e);
      else n_pass++;
    end
  endtask

  task automatic test_mode_exit();
    logic [20:0] e, o; string nm;
    do_reset();
    preset(12, 34);
    repeat (40) tick();
    rec("run_12_34_20", pk(12, 34, 20, 0, 0, 0));
    press_mode();
    rec("enter_set_hour", pk(12, 34, 20, 1, 0, 0));
    press_mode();
    rec("enter_set_min", pk(12, 34, 20, 2, 0, 0));
    btn_mode = 1'b1; cyc();
    rec("exit_tick_clear", pk(12, 34, 0, 0, 0, 1));
    btn_mode = 1'b0; cyc();
    rec("tick_clear_one_cycle", pk(12, 34, 0, 0, 0, 0));
    tick(); tick();
    rec("run_after_exit", pk(12, 34, 1, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      n_total++;
      if (o !== e) $display("FAIL %s got=%h expected=%h", nm, o, e);
      else n_pass++;
    end
  endtask

  task automatic test_set_wrap();
    logic [20:0] e, o; string nm;
    do_reset();
    press_mode(); press_inc(23);
    rec("hours_23", pk(23, 0, 0, 1, 0, 0));
    tick();
    rec("blink_on", pk(23, 0, 0, 1, 1, 0));
    tick();
    rec("blink_off", pk(23, 0, 0, 1, 0, 0));
    press_mode(); press_inc(59);
    rec("minutes_59", pk(23, 59, 0, 2, 0, 0));
    press_inc(1);
    rec("minutes_wrap", pk(23, 0, 0, 2, 0, 0));
    press_inc(7);
    rec("minutes_7", pk(23, 7, 0, 2, 0, 0));
    press_mode(); press_mode(); press_inc(1);
    rec("hours_wrap", pk(0, 7, 0, 1, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      n_total++;
      if (o !== e) $display("FAIL %s got=%h expected=%h", nm, o, e);
      else n_pass++;
    end
  endtask

  task automatic test_auto_inc();
    logic [20:0] e, o; string nm;
    do_reset();
    press_mode(); press_mode(); press_inc(10);
    rec("minutes_10", pk(0, 10, 0, 2, 0, 0));
    btn_inc = 1'b1; cyc();
    rec("press_edge", pk(0, 11, 0, 2, 0, 0));
    repeat (4) tick();
    rec("hold_not_yet", pk(0, 11, 0, 2, 0, 0));
    repeat (4) tick();
    rec("hold_repeat", pk(0, 15, 0, 2, 0, 0));
    btn_inc = 1'b0; cyc();
    repeat (3) tick();
    rec("released", pk(0, 15, 0, 2, 1, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      n_total++;
      if (o !== e) $display("FAIL %s got=%h expected=%h", nm, o, e);
      else n_pass++;
    end
  endtask

  task automatic test_simultaneous();
    logic [20:0] e, o; string nm;
    do_reset();
    press_mode(); press_inc(5);
    btn_mode = 1'b1; btn_inc = 1'b1; cyc();
    rec("mode_beats_inc", pk(5, 0, 0, 2, 0, 0));
    btn_mode = 1'b0; btn_inc = 1'b0; cyc();
    press_inc(1);
    rec("inc_after_simul", pk(5, 1, 0, 2, 0, 0));
    do_reset();
    tick();
    half_tick = 1'b1; btn_mode = 1'b1; cyc();
    rec("mode_beats_tick", pk(0, 0, 0, 1, 0, 0));
    half_tick = 1'b0; btn_mode = 1'b0; cyc();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      n_total++;
      if (o !== e) $display("FAIL %s got=%h expected=%h", nm, o, e);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_auto();
    logic [20:0] e, o; string nm;
    do_reset();
    press_mode(); press_inc(3); press_mode(); press_inc(10);
    btn_inc = 1'b1; cyc();
    repeat (6) tick();
    rec("auto_running", pk(3, 13, 0, 2, 0, 0));
    reset = 1'b1; half_tick = 1'b1; cyc();
    rec("reset_in_auto", pk(0, 0, 0, 0, 0, 0));
    reset = 1'b0; half_tick = 1'b0; cyc();
    repeat (4) tick();
    rec("held_inc_in_run", pk(0, 0, 2, 0, 0, 0));
    btn_inc = 1'b0; cyc();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      n_total++;
      if (o !== e) $display("FAIL %s got=%h expected=%h", nm, o, e);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_rollover();
    test_mode_exit();
    test_set_wrap();
    test_auto_inc();
    test_simultaneous();
    test_reset_mid_auto();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/clock_time_keeper.md
CLOCK_TIME_KEEPER -- requirements
Module: clock_time_keeper

Interface
REQ-001 SHALL have parameter: HOLD_HALF_TICKS, 4, number of half_tick pulses btn_inc must stay held before auto-increment starts (legal 1..7).
REQ-002 SHALL have port: ck  input  1  single system clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset; sampled on rising edge of ck.
REQ-004 SHALL have port: half_tick  input  1  one-cycle enable from the half-second tick generator.
REQ-005 SHALL have port: btn_mode  input  1  debounced mode button level.
REQ-006 SHALL have port: btn_inc  input  1  debounced increment button level.
REQ-007 SHALL have port: tick_clear  output  1  one-cycle request to clear/resync the half-second tick generator.
REQ-008 SHALL have port: hours  output  5  current hour, 0..23.
REQ-009 SHALL have port: minutes  output  6  current minute, 0..59.
REQ-010 SHALL have port: seconds  output  6  current second, 0..59.
REQ-011 SHALL have port: mode  output  2  00 RUN, 01 SET_HOUR, 10 SET_MIN; 11 never driven.
REQ-012 SHALL have port: blink  output  1  blanking phase for the field being set; 0 in RUN.

Function
REQ-013 SHALL register btn_mode and btn_inc once and detect rising edges as (level & ~previous level); edges are single-cycle.
REQ-014 SHALL implement FSM RUN -> SET_HOUR -> SET_MIN -> RUN, advancing only on a btn_mode rising edge.
REQ-015 In RUN, SHALL toggle an internal half-phase bit on each half_tick and increment seconds on every half_tick that finds half-phase = 1 (one second per two pulses).
REQ-016 Seconds wrap 59->0 SHALL carry +1 into minutes; minutes wrap 59->0 SHALL carry +1 into hours; hours wrap 23->0; 23:59:59 -> 00:00:00 in one cycle.
REQ-017 In SET_HOUR/SET_MIN, seconds and half-phase SHALL hold; a btn_inc rising edge SHALL increment the selected field by 1 the following cycle, wrapping within its range with no carry to any other field.
REQ-018 In set states, a hold counter SHALL count half_tick pulses while btn_inc is high and clear when btn_inc is low; once it reaches HOLD_HALF_TICKS, each further half_tick while held SHALL increment the selected field by 1 (saturate counter, no overflow).
REQ-019 blink SHALL toggle on each half_tick in set states, load 0 on entry to any set state, and be 0 in RUN.
REQ-020 On transition SET_MIN -> RUN, seconds SHALL load 0, half-phase SHALL load 0, and tick_clear SHALL be 1 for exactly that one cycle; tick_clear SHALL be 0 at all other times.
REQ-021 Simultaneous btn_mode edge and btn_inc edge/auto-increment in one cycle: mode transition wins, increment discarded, hold counter cleared.
REQ-022 Simultaneous half_tick and btn_mode edge in RUN: transition wins, that half_tick does not advance time or half-phase.
REQ-023 Hold counter SHALL clear on every state transition.
REQ-024 Outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-025 With reset = 1 at a ck edge: hours = 0, minutes = 0, seconds = 0, mode = RUN, blink = 0, tick_clear = 0, half-phase = 0, hold counter = 0, button history registers = 0.
REQ-026 Reset SHALL override all other inputs, including mid-set-mode and mid-auto-increment.

Verification
REQ-027 Preset 23:59:58 via set mode, RUN, 4 half_ticks -> 23:59:59 after 2nd, 00:00:00 after 4th.
REQ-028 RUN 12:34:20, two btn_mode edges -> mode 10; one btn_mode edge -> mode 00, seconds = 0, tick_clear high exactly 1 cycle, hours/minutes unchanged.
REQ-029 SET_HOUR at 23, one btn_inc edge -> hours 0, minutes unchanged; SET_MIN at 59, edge -> minutes 0, hours unchanged.
REQ-030 SET_MIN at 10, btn_inc held for 8 half_ticks with default parameter -> 11 after press edge, 15 after 8th half_tick; release -> no further change.
REQ-031 btn_mode and btn_inc rising in same cycle while in SET_HOUR at 5 -> mode 10, hours stays 5.
REQ-032 reset asserted during auto-increment in SET_MIN -> next cycle 00:00:00, mode 00, blink 0; held btn_inc after reset produces no change in RUN.
